// File: rtl/key_reader_pkg.sv
// key_reader_pkg: shared FSM state type, default timing and counter sizing for key_reader
package key_reader_pkg;
  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } key_state_t;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_LONG_CYCLES     = 50_000_000;
  localparam int DEF_REPEAT_CYCLES   = 10_000_000;
  function automatic int cnt_width(input int d, input int l, input int r);
    int m;
    m = (d > l) ? d : l;
    m = (m > r) ? m : r;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one push-button channel -- synchronizer, debounce FSM, hold/repeat counter
//   clk_50M, reset_n : clock, async active-low reset
//   i_key_n          : raw button, 0 = pressed
//   o_level          : debounced state, 1 = pressed
//   o_press/o_release: one-cycle strobes on accepted press/release
//   o_long/o_repeat  : one-cycle hold strobes
//   o_press_d        : combinational "press accepted at this edge", lets the top register key_code alongside o_press
module key_debounce_ch
  import key_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int CW              = cnt_width(DEF_DEBOUNCE_CYCLES, DEF_LONG_CYCLES, DEF_REPEAT_CYCLES)
) (
  input  logic clk_50M,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat,
  output logic o_press_d
);
  // The entry edge counts as the first stable sample, so acceptance comes when the
  // increment would reach DEBOUNCE_CYCLES-1, i.e. after DEBOUNCE_CYCLES stable samples.
  localparam logic [CW-1:0] C_DB_LAST = CW'(DEBOUNCE_CYCLES - 2);
  localparam logic [CW-1:0] C_LONG    = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] C_REPEAT  = CW'(LONG_CYCLES - 1 + REPEAT_CYCLES);
  key_state_t      r_state;
  logic            r_meta, r_sync;
  logic [CW-1:0]   r_db, r_hold;
  logic            r_level, r_press, r_release, r_long, r_repeat;
  logic            w_db_done, w_long_hit, w_rep_hit;
  logic [CW-1:0]   w_hold_inc, w_hold_nx;
  assign w_db_done  = (r_db == C_DB_LAST);
  assign w_hold_inc = r_hold + 1'b1;
  assign w_long_hit = (w_hold_inc == C_LONG);
  assign w_rep_hit  = (w_hold_inc == C_REPEAT);
  // Wrap back to the long point so the repeat phase never overflows the counter.
  assign w_hold_nx  = w_rep_hit ? C_LONG : w_hold_inc;
  assign o_press_d  = (r_state == PRESS_CHK) && !r_sync && w_db_done;
  assign o_level    = r_level;
  assign o_press    = r_press;
  assign o_release  = r_release;
  assign o_long     = r_long;
  assign o_repeat   = r_repeat;
  always_ff @(posedge clk_50M or negedge reset_n)
    if (!reset_n) begin
      r_meta    <= 1'b1;
      r_sync    <= 1'b1;
      r_state   <= RELEASED;
      r_db      <= '0;
      r_hold    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_meta    <= i_key_n;
      r_sync    <= r_meta;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      case (r_state)
        RELEASED:
          if (!r_sync) begin
            r_state <= PRESS_CHK;
            r_db    <= '0;
          end
        PRESS_CHK:
          if (r_sync) r_state <= RELEASED;
          else if (w_db_done) begin
            r_state <= PRESSED;
            r_level <= 1'b1;
            r_press <= 1'b1;
            r_hold  <= '0;
          end else r_db <= r_db + 1'b1;
        PRESSED: begin
          r_hold   <= w_hold_nx;
          r_long   <= w_long_hit;
          r_repeat <= w_rep_hit;
          if (r_sync) begin
            r_state <= RELEASE_CHK;
            r_db    <= '0;
          end
        end
        RELEASE_CHK:
          // Hold time keeps advancing here, but any long/repeat event falling due is dropped.
          if (!r_sync) begin
            r_state <= PRESSED;
            r_hold  <= w_hold_nx;
          end else if (w_db_done) begin
            r_state   <= RELEASED;
            r_level   <= 1'b0;
            r_release <= 1'b1;
            r_hold    <= '0;
          end else begin
            r_db   <= r_db + 1'b1;
            r_hold <= w_hold_nx;
          end
        default: r_state <= RELEASED;
      endcase
    end
endmodule

// File: rtl/key_reader.sv
// key_reader: N_KEYS debounced push-buttons with press/release/long/repeat strobes and a press priority encoder
//   clk_50M, reset_n : 50 MHz clock, async active-low reset
//   key_n            : raw buttons, 0 = pressed
//   key_level        : debounced state per key
//   press_pulse/release_pulse/long_pulse/repeat_pulse : one-cycle strobes per key
//   key_valid/key_code : registered alongside press_pulse; lowest pressed index
module key_reader
  import key_reader_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                      clk_50M,
  input  logic                      reset_n,
  input  logic [N_KEYS-1:0]         key_n,
  output logic [N_KEYS-1:0]         key_level,
  output logic [N_KEYS-1:0]         press_pulse,
  output logic [N_KEYS-1:0]         release_pulse,
  output logic [N_KEYS-1:0]         long_pulse,
  output logic [N_KEYS-1:0]         repeat_pulse,
  output logic                      key_valid,
  output logic [$clog2(N_KEYS)-1:0] key_code
);
  localparam int CW     = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
  localparam int CODE_W = $clog2(N_KEYS);
  logic [N_KEYS-1:0] w_press_d;
  logic [CODE_W-1:0] w_code;
  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .CW             (CW)
    ) u_ch (
      .clk_50M  (clk_50M),
      .reset_n  (reset_n),
      .i_key_n  (key_n[i]),
      .o_level  (key_level[i]),
      .o_press  (press_pulse[i]),
      .o_release(release_pulse[i]),
      .o_long   (long_pulse[i]),
      .o_repeat (repeat_pulse[i]),
      .o_press_d(w_press_d[i])
    );
  end
  // Scan downward so the lowest pressed index wins.
  always_comb begin
    w_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--)
      if (w_press_d[i]) w_code = CODE_W'(i);
  end
  always_ff @(posedge clk_50M or negedge reset_n)
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
    end else begin
      r_valid <= |w_press_d;
      r_code  <= w_code;
    end
  assign key_valid = r_valid;
  assign key_code  = r_code;
endmodule

// File: tb/tb_key_reader.sv
// tb_key_reader: directed self-checking bench for key_reader with short timing parameters
module tb_key_reader;
  localparam int N = 4, D = 8, L = 32, R = 8;
  logic         clk_50M = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] key_level, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic         key_valid;
  logic [1:0]   key_code;
  int           n_chk = 0;
  int           n_bad = 0;
  logic         seen;
  key_reader #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)
  ) dut (
    .clk_50M      (clk_50M),
    .reset_n      (reset_n),
    .key_n        (key_n),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .key_valid    (key_valid),
    .key_code     (key_code)
  );
  always #10 clk_50M = ~clk_50M;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_50M);
      #1;
    end
  endtask
  function automatic logic [31:0] all_out();
    return {9'd0, key_level, press_pulse, release_pulse, long_pulse, repeat_pulse, key_valid, key_code};
  endfunction
  initial begin
    tick(3);
    chk("reset_outputs", all_out(), 0);
    reset_n = 1'b1;
    tick(2);
    key_n[0] = 1'b0;
    tick(9);
    chk("k0_early", {key_level[0], press_pulse[0]}, 0);
    tick();
    chk("k0_level", key_level, 4'b0001);
    chk("k0_press", press_pulse, 4'b0001);
    chk("k0_valid", key_valid, 1);
    chk("k0_code", key_code, 0);
    tick();
    chk("k0_one_cycle", {press_pulse, key_valid}, 0);
    key_n[0] = 1'b1;
    tick(9);
    chk("k0_rel_early", release_pulse, 0);
    tick();
    chk("k0_release", release_pulse, 4'b0001);
    chk("k0_rel_level", key_level, 0);
    seen = 1'b0;
    repeat (3) begin
      key_n[1] = 1'b0;
      repeat (5) begin
        tick();
        seen |= press_pulse[1] | release_pulse[1] | key_level[1];
      end
      key_n[1] = 1'b1;
      repeat (5) begin
        tick();
        seen |= press_pulse[1] | release_pulse[1] | key_level[1];
      end
    end
    repeat (10) begin
      tick();
      seen |= press_pulse[1] | release_pulse[1] | key_level[1];
    end
    chk("k1_bounce", seen, 0);
    key_n[2] = 1'b0;
    tick(10);
    chk("k2_press", press_pulse, 4'b0100);
    for (int k = 1; k <= 60; k++) begin
      tick();
      chk($sformatf("k2_long@%0d", k), long_pulse, (k == 31) ? 4'b0100 : 4'b0000);
      chk($sformatf("k2_repeat@%0d", k), repeat_pulse,
          (k == 39 || k == 47 || k == 55) ? 4'b0100 : 4'b0000);
    end
    key_n[2] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      if (k == 3) key_n[2] = 1'b0;
      if (k == 8) key_n[2] = 1'b1;
      tick();
      chk($sformatf("k2_no_release@%0d", k), {release_pulse[2], key_level[2]}, 2'b01);
    end
    tick();
    chk("k2_release", release_pulse, 4'b0100);
    chk("k2_rel_level", key_level[2], 0);
    tick(3);
    key_n = 4'b0101;
    tick(9);
    chk("k13_early", press_pulse, 0);
    tick();
    chk("k13_press", press_pulse, 4'b1010);
    chk("k13_code", key_code, 1);
    chk("k13_valid", key_valid, 1);
    key_n = '1;
    tick(12);
    key_n[0] = 1'b0;
    tick(12);
    chk("k0_held", key_level, 4'b0001);
    reset_n = 1'b0;
    #1;
    chk("async_reset", all_out(), 0);
    tick(2);
    chk("in_reset", all_out(), 0);
    reset_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("post_rst_quiet@%0d", k), press_pulse, 0);
    end
    tick();
    chk("post_rst_press", press_pulse, 4'b0001);
    chk("post_rst_valid", key_valid, 1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/key_reader.md
KEY_READER -- requirements
Module: key_reader

Interface
REQ-001 The module SHALL have parameter N_KEYS, default 4, giving the number of push-button channels.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, giving the stable cycles required to accept a press or release (20 ms at 50 MHz).
REQ-003 The module SHALL have parameter LONG_CYCLES, default 50_000_000, giving the held cycles after accepted press until long_pulse (1 s).
REQ-004 The module SHALL have parameter REPEAT_CYCLES, default 10_000_000, giving the auto-repeat period after long_pulse (200 ms).
REQ-005 Port clk_50M SHALL be an input, 1 bit: the 50 MHz system clock, with all logic on its rising edge.
REQ-006 Port reset_n SHALL be an input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port key_n SHALL be an input, N_KEYS bits: raw asynchronous buttons, active-low (0 = pressed).
REQ-008 Port key_level SHALL be an output, N_KEYS bits: debounced state, 1 = pressed.
REQ-009 Port press_pulse SHALL be an output, N_KEYS bits: one-cycle strobe on accepted press.
REQ-010 Port release_pulse SHALL be an output, N_KEYS bits: one-cycle strobe on accepted release.
REQ-011 Port long_pulse SHALL be an output, N_KEYS bits: one-cycle strobe when the hold time reaches LONG_CYCLES.
REQ-012 Port repeat_pulse SHALL be an output, N_KEYS bits: one-cycle strobe every REPEAT_CYCLES after long_pulse while held.
REQ-013 Port key_valid SHALL be an output, 1 bit: high in any cycle where some press_pulse bit is high.
REQ-014 Port key_code SHALL be an output, $clog2(N_KEYS) bits: index of the lowest-numbered key with press_pulse high; 0 when key_valid is low.

Function
REQ-015 Each key_n bit SHALL pass through a 2-flop synchronizer, with flops resetting to 1, before any other use.
REQ-016 Each channel SHALL run an independent FSM with states RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
REQ-017 In RELEASED, a synchronized low SHALL move the FSM to PRESS_CHK and clear the debounce counter.
REQ-018 In PRESS_CHK, the counter SHALL increment each cycle the input is low; a synchronized high SHALL return the FSM to RELEASED with no strobe (bounce rejected).
REQ-019 In PRESS_CHK, when the counter reaches DEBOUNCE_CYCLES-1 with the input still low, the FSM SHALL enter PRESSED, set key_level, pulse press_pulse for one cycle, and clear the hold counter.
REQ-020 In PRESSED, the hold counter SHALL increment each cycle; long_pulse SHALL fire once at LONG_CYCLES-1, and repeat_pulse SHALL fire every REPEAT_CYCLES cycles thereafter with no upper limit.
REQ-021 Counters SHALL wrap modulo the repeat period rather than overflow; counter widths SHALL be $clog2 of the largest parameter plus 1.
REQ-022 In PRESSED, a synchronized high SHALL move the FSM to RELEASE_CHK and clear the debounce counter while key_level stays 1.
REQ-023 In RELEASE_CHK, a synchronized low SHALL return the FSM to PRESSED with no strobe, and the hold counter SHALL keep counting.
REQ-024 In RELEASE_CHK, reaching DEBOUNCE_CYCLES-1 high cycles SHALL move the FSM to RELEASED, clear key_level, pulse release_pulse, and reset the hold counter.
REQ-025 A hold-counter event (long or repeat) due during RELEASE_CHK SHALL be suppressed and not deferred.
REQ-026 Latency from a clean input edge to the key_level change SHALL be DEBOUNCE_CYCLES+2 clocks, with up to 1 extra clock of sampling uncertainty.
REQ-027 All outputs SHALL be registered; press_pulse, key_valid and key_code SHALL be asserted in the same cycle.
REQ-028 Simultaneous presses on several keys SHALL each assert their own press_pulse bit, and key_code SHALL report the lowest index.
REQ-029 A channel SHALL never assert press_pulse and release_pulse in the same cycle, nor two press_pulses without an intervening release_pulse.

Reset
REQ-030 Asserting reset_n SHALL immediately put all FSMs in RELEASED, zero all counters and outputs, and set the synchronizers to 1.
REQ-031 A key still held when reset_n deasserts SHALL undergo a full new debounce and produce a new press_pulse.
REQ-032 A key that is pressed or released while reset_n is asserted SHALL produce no strobe.

Structure
REQ-033 Package key_reader_pkg SHALL hold the FSM state enum and the default timing constants.
REQ-034 Sub-module key_debounce_ch SHALL contain the synchronizer, FSM and counters for one key, and SHALL be instantiated N_KEYS times by generate.
REQ-035 The top level SHALL contain only the instances and the priority encoder for key_code/key_valid.

Verification (bench parameters DEBOUNCE_CYCLES=8, LONG_CYCLES=32, REPEAT_CYCLES=8)
REQ-036 The bench SHALL drive key_n[0] low cleanly and expect key_level[0] rise plus press_pulse[0], key_valid=1, key_code=0 for one cycle, 10 clocks later.
REQ-037 The bench SHALL toggle key_n[1] low for 5 clocks then high, 3 times, and expect no strobes and key_level[1]=0 throughout.
REQ-038 The bench SHALL hold key2 for 60 clocks after acceptance and expect long_pulse[2] at hold cycle 31, then repeat_pulse[2] at cycles 39, 47 and 55.
REQ-039 The bench SHALL release key2 with a 3-clock bounce back to low, then release cleanly, and expect one release_pulse[2] only after 8 stable high cycles.
REQ-040 The bench SHALL press keys 1 and 3 in the same cycle and expect press_pulse=4'b1010 and key_code=1 in one cycle.
REQ-041 The bench SHALL pulse reset_n low for 2 clocks while key0 is held and expect all outputs 0 immediately, then press_pulse[0] again 10 clocks after reset release.
